obi_rr_arbiter: RTL and testbench

- Parametrised N-master to 1-slave OBI arbiter. It generalises the fixed instr/data dual-port bus front end so that any number of core-side masters can share one memory or peripheral port.
- Masters include instruction fetch, LSU, debug module and DMA.
- Round-robin fairness; in-order response routing through an outstanding-transaction ID FIFO.
- Multiple outstanding transactions supported.
- Sits between cv32e40p-style master ports and the bus/memory slave.

---
 rtl/obi_pkg.sv | 32 +++
 rtl/obi_rr_arbiter_if.sv | 48 ++++
 rtl/obi_id_fifo.sv | 64 ++++++
 rtl/obi_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_obi_rr_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_pkg.sv
// Shared OBI types and helpers used by the arbiter, its ID FIFO and the bus interface.
package obi_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;

    // Address-phase payload of one OBI request.
    typedef struct packed {
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_ADDR_W-1:0] addr;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

    // Response-phase payload.
    typedef struct packed {
        logic [OBI_DATA_W-1:0] rdata;
    } obi_rsp_t;

    // Address-phase lock state of the arbiter.
    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/obi_rr_arbiter_if.sv
// Bus bundle between the core-side masters, the arbiter and the shared slave port.
// Handshakes: the address phase completes in a cycle where req and gnt are both high;
// a master holding req without gnt must keep req and its payload stable. A response
// is delivered in any cycle with rvalid high; there is no back-pressure on responses.
interface obi_rr_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
);
    import obi_pkg::*;

    logic [NUM_MASTERS-1:0]          m_req_i;
    logic [NUM_MASTERS-1:0]          m_we_i;
    logic [NUM_MASTERS*DATA_W/8-1:0] m_be_i;
    logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i;
    logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_i;
    logic [NUM_MASTERS-1:0]          m_gnt_o;
    logic [NUM_MASTERS-1:0]          m_rvalid_o;
    logic [DATA_W-1:0]               m_rdata_o;
    logic                            s_req_o;
    logic                            s_we_o;
    logic [DATA_W/8-1:0]             s_be_o;
    logic [ADDR_W-1:0]               s_addr_o;
    logic [DATA_W-1:0]               s_wdata_o;
    logic                            s_gnt_i;
    logic                            s_rvalid_i;
    logic [DATA_W-1:0]               s_rdata_i;
    lock_state_e                     dbg_lock_state;

    // Arbiter side: it serves the masters and drives the shared slave port.
    modport slave (
        input  m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i,
        input  s_gnt_i, s_rvalid_i, s_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o,
        output s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
        output dbg_lock_state
    );

    // Environment side: the masters plus the memory/peripheral slave.
    modport master (
        output m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i,
        output s_gnt_i, s_rvalid_i, s_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o,
        input  s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
        input  dbg_lock_state
    );

endinterface

// File: rtl/obi_id_fifo.sv
// Circular FIFO of master indices for granted transactions still awaiting a response.
module obi_id_fifo
    import obi_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [W-1:0]                   data_i,
    output logic [W-1:0]                   data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int unsigned PW = idx_w(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap explicitly so any depth works.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// N-master to 1-slave OBI arbiter: round-robin address phase with lock-until-grant,
// in-order response routing through an ID FIFO of granted master indices.
module obi_rr_arbiter
    import obi_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    obi_rr_arbiter_if.slave                        bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   proto_err_o
);
    localparam int unsigned IW   = idx_w(NUM_MASTERS);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

    lock_state_e   lock_q, lock_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          proto_err_q, proto_err_d;
    logic [IW-1:0] rr_idx, winner, head;
    logic          any_req, s_req, handshake, pop, fifo_full, fifo_empty;

    // Round-robin scan, walked downward so the requester nearest to ptr_q is written last.
    always_comb begin
        int unsigned   j;
        logic [IW-1:0] jj;
        j       = 0;
        jj      = '0;
        rr_idx  = ptr_q;
        any_req = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            j = 32'(ptr_q) + 32'(i);
            if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
            jj = j[IW-1:0];
            if (bus.m_req_i[jj]) begin
                rr_idx  = jj;
                any_req = 1'b1;
            end
        end
    end

    // A held lock overrides arbitration; a full FIFO or reset blocks the slave request.
    assign winner    = (lock_q == LOCK_HELD) ? lock_idx_q : rr_idx;
    assign s_req     = rst_ni && !fifo_full && ((lock_q == LOCK_HELD) || any_req);
    assign handshake = s_req && bus.s_gnt_i;
    assign pop       = bus.s_rvalid_i && !fifo_empty;

    assign bus.s_req_o        = s_req;
    assign bus.m_rdata_o      = bus.s_rdata_i;
    assign bus.dbg_lock_state = lock_q;
    assign proto_err_o        = proto_err_q;

    // Payload mux to the slave, one-hot grant to the winner, one-hot response to the FIFO head.
    always_comb begin
        bus.s_we_o     = 1'b0;
        bus.s_be_o     = '0;
        bus.s_addr_o   = '0;
        bus.s_wdata_o  = '0;
        bus.m_gnt_o    = '0;
        bus.m_rvalid_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (winner == k[IW-1:0]) begin
                bus.s_we_o     = bus.m_we_i[k];
                bus.s_be_o     = bus.m_be_i[k*BE_W +: BE_W];
                bus.s_addr_o   = bus.m_addr_i[k*ADDR_W +: ADDR_W];
                bus.s_wdata_o  = bus.m_wdata_i[k*DATA_W +: DATA_W];
                bus.m_gnt_o[k] = handshake;
            end
            if (head == k[IW-1:0]) bus.m_rvalid_o[k] = pop;
        end
    end

    // Next pointer, lock and error state.
    always_comb begin
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
        proto_err_d = proto_err_q || (bus.s_rvalid_i && fifo_empty);
        if (handshake) begin
            ptr_d  = (winner == LAST_IDX) ? '0 : winner + 1'b1;
            lock_d = LOCK_IDLE;
        end else if (s_req) begin
            lock_d     = LOCK_HELD;
            lock_idx_d = winner;
        end
    end

    // Lock state machine together with the round-robin pointer and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q      <= LOCK_IDLE;
            lock_idx_q  <= '0;
            ptr_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            ptr_q       <= ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .pop_i   (pop),
        .data_i  (winner),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Randomised and directed bench for obi_rr_arbiter with three masters (non-power-of-2 wrap).
module tb_obi_rr_arbiter;
    import obi_pkg::*;

    localparam int N    = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXO = 2;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk_i;
    logic          rst_ni;
    logic [CW-1:0] outstanding_o;
    logic          proto_err_o;

    int total;
    int bad;

    // Stimulus state
    obi_req_t      pay [N];
    logic [N-1:0]  cur_req;
    logic          cur_gnt;
    logic          cur_rv;
    logic [DW-1:0] cur_rdata;

    // Reference model: next-in-line pointer, locked master (-1 = none), queue of owners
    int            m_ptr;
    int            m_lock;
    logic [1:0]    exp_q[$];
    bit            m_perr;
    bit            e_sreq, e_hs, e_pop;
    int            e_win;

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    obi_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    obi_rr_arbiter #(
        .NUM_MASTERS     (N),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .bus           (bus),
        .outstanding_o (outstanding_o),
        .proto_err_o   (proto_err_o)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    task automatic model_reset();
        m_ptr  = 0;
        m_lock = -1;
        exp_q.delete();
        m_perr = 1'b0;
        e_sreq = 1'b0;
        e_hs   = 1'b0;
        e_pop  = 1'b0;
        e_win  = 0;
    endtask

    task automatic new_payload(input int k);
        pay[k].we    = 1'($urandom_range(0, 1));
        pay[k].be    = 4'($urandom_range(0, 15));
        pay[k].addr  = $urandom;
        pay[k].wdata = $urandom;
    endtask

    // Expected outputs for the current inputs, compared against the DUT.
    task automatic model_check();
        bit           full;
        bit           any;
        int           win;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        full = (exp_q.size() == MAXO);
        any  = 1'b0;
        win  = 0;
        if (m_lock >= 0) begin
            any = 1'b1;
            win = m_lock;
        end else begin
            for (int i = 0; i < N; i++) begin
                int j;
                j = (m_ptr + i) % N;
                if (!any && cur_req[j]) begin
                    any = 1'b1;
                    win = j;
                end
            end
        end
        e_sreq = any && !full;
        e_hs   = e_sreq && cur_gnt;
        e_win  = win;
        e_pop  = cur_rv && (exp_q.size() != 0);
        eg = '0;
        if (e_hs) eg[win] = 1'b1;
        er = '0;
        if (e_pop) er[exp_q[0]] = 1'b1;
        check("s_req", bus.s_req_o, e_sreq);
        check("m_gnt", bus.m_gnt_o, eg);
        check("m_rvalid", bus.m_rvalid_o, er);
        if (e_pop) check("m_rdata", bus.m_rdata_o, cur_rdata);
        if (e_sreq) begin
            check("s_addr", bus.s_addr_o, pay[win].addr);
            check("s_we", bus.s_we_o, pay[win].we);
            check("s_be", bus.s_be_o, pay[win].be);
            check("s_wdata", bus.s_wdata_o, pay[win].wdata);
        end
        check("outstanding", outstanding_o, exp_q.size());
        check("proto_err", proto_err_o, m_perr);
    endtask

    // Clock edge: retire the response, record the grant, update lock and pointer.
    task automatic advance();
        logic [1:0] dummy;
        @(posedge clk_i);
        if (cur_rv && exp_q.size() == 0) m_perr = 1'b1;
        if (e_pop) dummy = exp_q.pop_front();
        if (e_hs) begin
            exp_q.push_back(2'(e_win));
            m_ptr  = (e_win + 1) % N;
            m_lock = -1;
            new_payload(e_win);
        end else if (e_sreq) begin
            m_lock = e_win;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_bus();
        for (int k = 0; k < N; k++) begin
            bus.m_we_i[k]                = pay[k].we;
            bus.m_be_i[k*BW +: BW]       = pay[k].be;
            bus.m_addr_i[k*AW +: AW]     = pay[k].addr;
            bus.m_wdata_i[k*DW +: DW]    = pay[k].wdata;
        end
        bus.m_req_i    = cur_req;
        bus.s_gnt_i    = cur_gnt;
        bus.s_rvalid_i = cur_rv;
        bus.s_rdata_i  = cur_rdata;
    endtask

    task automatic apply(input logic [N-1:0] r, input logic g, input logic v, input logic [DW-1:0] d);
        @(negedge clk_i);
        cur_req   = r;
        cur_gnt   = g;
        cur_rv    = v;
        cur_rdata = d;
        drive_bus();
        #1;
        model_check();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni    = 1'b0;
        cur_req   = '0;
        cur_gnt   = 1'b0;
        cur_rv    = 1'b0;
        cur_rdata = '0;
        drive_bus();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    // ---------------- main sequence ----------------
    logic [N-1:0] seq_a [4];
    logic [N-1:0] seq_b [4];

    initial begin
        total = 0;
        bad   = 0;
        for (int k = 0; k < N; k++) new_payload(k);
        model_reset();
        rst_ni    = 1'b0;
        cur_req   = '1;
        cur_gnt   = 1'b1;
        cur_rv    = 1'b1;
        cur_rdata = 32'h1234_5678;
        drive_bus();
        #2;
        // Held in reset with every input active
        check("rst_s_req", bus.s_req_o, 1'b0);
        check("rst_m_gnt", bus.m_gnt_o, '0);
        check("rst_m_rvalid", bus.m_rvalid_o, '0);
        check("rst_outstanding", outstanding_o, '0);
        check("rst_proto_err", proto_err_o, 1'b0);
        do_reset();

        // Single write from master 0, immediate grant, response one cycle later
        pay[0] = '{we: 1'b1, be: 4'hF, addr: 32'h0000_2000, wdata: 32'hDEAD_BEEF};
        apply(3'b001, 1'b1, 1'b0, '0);
        check("t1_gnt", bus.m_gnt_o, 3'b001);
        check("t1_addr", bus.s_addr_o, 32'h0000_2000);
        check("t1_wdata", bus.s_wdata_o, 32'hDEAD_BEEF);
        advance();
        apply(3'b000, 1'b0, 1'b1, 32'h0000_00AA);
        check("t1_rvalid", bus.m_rvalid_o, 3'b001);
        check("t1_outst1", outstanding_o, 2'd1);
        advance();
        apply(3'b000, 1'b0, 1'b0, '0);
        check("t1_outst0", outstanding_o, 2'd0);
        advance();

        // Round robin: masters 0,1 alternate; then all three rotate and wrap
        seq_a = '{3'b001, 3'b010, 3'b001, 3'b010};
        seq_b = '{3'b001, 3'b010, 3'b100, 3'b001};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            apply(3'b011, 1'b1, (c != 0), 32'(c));
            check("rr2_gnt", bus.m_gnt_o, seq_a[c]);
            advance();
        end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            apply(3'b111, 1'b1, (c != 0), 32'(c));
            check("rr3_gnt", bus.m_gnt_o, seq_b[c]);
            advance();
        end

        // Lock: master 1 stalled three cycles while master 0 joins; master 1 wins
        do_reset();
        pay[1].addr = 32'h1000_0100;
        apply(3'b010, 1'b0, 1'b0, '0);
        check("lk_addr0", bus.s_addr_o, 32'h1000_0100);
        advance();
        for (int c = 0; c < 2; c++) begin
            apply(3'b011, 1'b0, 1'b0, '0);
            check("lk_addr", bus.s_addr_o, 32'h1000_0100);
            check("lk_gnt_hold", bus.m_gnt_o, 3'b000);
            advance();
        end
        apply(3'b011, 1'b1, 1'b0, '0);
        check("lk_addr3", bus.s_addr_o, 32'h1000_0100);
        check("lk_gnt", bus.m_gnt_o, 3'b010);
        advance();

        // Full FIFO blocks requests; responses route in grant order 1 then 0
        do_reset();
        apply(3'b010, 1'b1, 1'b0, '0);
        advance();
        apply(3'b001, 1'b1, 1'b0, '0);
        advance();
        apply(3'b011, 1'b1, 1'b0, '0);
        check("full_outst", outstanding_o, 2'd2);
        check("full_s_req", bus.s_req_o, 1'b0);
        advance();
        apply(3'b011, 1'b1, 1'b1, 32'h11);
        check("full_rv1", bus.m_rvalid_o, 3'b010);
        check("full_rd1", bus.m_rdata_o, 32'h11);
        check("full_no_unblock", bus.s_req_o, 1'b0);
        advance();
        apply(3'b000, 1'b0, 1'b1, 32'h22);
        check("full_rv0", bus.m_rvalid_o, 3'b001);
        check("full_rd0", bus.m_rdata_o, 32'h22);
        advance();

        // Same-cycle push (master 0) and pop (head master 1)
        do_reset();
        apply(3'b010, 1'b1, 1'b0, '0);
        advance();
        apply(3'b001, 1'b1, 1'b1, 32'h33);
        check("pp_gnt", bus.m_gnt_o, 3'b001);
        check("pp_rv", bus.m_rvalid_o, 3'b010);
        advance();
        apply(3'b000, 1'b0, 1'b1, 32'h44);
        check("pp_outst", outstanding_o, 2'd1);
        check("pp_rv_next", bus.m_rvalid_o, 3'b001);
        advance();

        // Randomised traffic; locked masters keep requesting
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [N-1:0] r;
            logic         v;
            r = N'($urandom_range(0, (1 << N) - 1));
            if (m_lock >= 0) r[m_lock] = 1'b1;
            v = (exp_q.size() != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            apply(r, 1'($urandom_range(0, 1)), v, $urandom);
            advance();
        end

        // Response with nothing outstanding sets a sticky error
        do_reset();
        apply(3'b000, 1'b0, 1'b1, 32'hAB);
        check("pe_rvalid", bus.m_rvalid_o, 3'b000);
        advance();
        for (int c = 0; c < 3; c++) begin
            apply(3'b000, 1'b0, 1'b0, '0);
            check("pe_sticky", proto_err_o, 1'b1);
            advance();
        end

        // Asynchronous reset mid-burst, then a stale response
        apply(3'b011, 1'b1, 1'b0, '0);
        advance();
        apply(3'b011, 1'b0, 1'b1, 32'h55);
        @(posedge clk_i);
        #3;
        bus.s_gnt_i = 1'b1;
        rst_ni      = 1'b0;
        #1;
        check("ar_s_req", bus.s_req_o, 1'b0);
        check("ar_m_gnt", bus.m_gnt_o, 3'b000);
        check("ar_m_rvalid", bus.m_rvalid_o, 3'b000);
        check("ar_outst", outstanding_o, 2'd0);
        check("ar_proto_err", proto_err_o, 1'b0);
        @(negedge clk_i);
        cur_req = '0;
        cur_gnt = 1'b0;
        cur_rv  = 1'b0;
        drive_bus();
        rst_ni = 1'b1;
        model_reset();
        apply(3'b000, 1'b0, 1'b1, 32'h66);
        check("ar_stale_rv", bus.m_rvalid_o, 3'b000);
        advance();
        apply(3'b000, 1'b0, 1'b0, '0);
        check("ar_stale_err", proto_err_o, 1'b1);
        advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
